// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multi-cycle load/store stage with RAM request/ready handshake
//
// Purpose: issues byte/half/word loads and stores to a variable-latency RAM,
// stalls the pipeline while an access is in flight, flags misaligned addresses
// and aborts an access the RAM never answers.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   mem_*_in, mem_write_data, address_in, flush
//                            instruction presented by the EX/MEM register
//   ram_en, ram_write_en, ram_addr, ram_write_data, ram_ready, ram_read_data
//                            RAM request/ready interface
//   stall_req, done          pipeline hold and one-cycle completion pulse
//   load_data_out            extracted and extended load result
//   addr_error_load/store, bad_vaddr, timeout_error
//                            exception pulses and offending address
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_flag_in,
    input  logic                  mem_write_flag_in,
    input  logic                  mem_sign_ext_flag_in,
    input  logic [3:0]            mem_sel_in,
    input  logic [31:0]           mem_write_data,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic                  flush,
    output logic                  ram_en,
    output logic [3:0]            ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_write_data,
    input  logic                  ram_ready,
    input  logic [31:0]           ram_read_data,
    output logic                  stall_req,
    output logic                  done,
    output logic [31:0]           load_data_out,
    output logic                  addr_error_load,
    output logic                  addr_error_store,
    output logic [ADDR_WIDTH-1:0] bad_vaddr,
    output logic                  timeout_error
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  state_q;
    size_t                   size_q;
    logic                    store_q;
    logic                    sign_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              we_q;
    logic [31:0]             wdata_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [31:0]             load_q;
    logic                    err_load_q;
    logic                    err_store_q;
    logic [ADDR_WIDTH-1:0]   bad_vaddr_q;
    logic                    timeout_q;

    // Request decode in IDLE
    logic        sel_byte, sel_half, sel_word, request, aligned, in_access;
    size_t       size_d;
    logic [3:0]  we_d;
    logic [31:0] wdata_d;

    assign sel_byte = (mem_sel_in == 4'b0001);
    assign sel_half = (mem_sel_in == 4'b0011);
    assign sel_word = (mem_sel_in == 4'b1111);
    // rst gates the request so nothing asserts combinationally while in reset
    assign request  = rst && (state_q == S_IDLE) && (mem_read_flag_in || mem_write_flag_in)
                      && (sel_byte || sel_half || sel_word) && !flush;
    assign aligned  = sel_byte || (sel_half && !address_in[0])
                      || (sel_word && (address_in[1:0] == 2'b00));

    always_comb begin
        size_d  = SZ_WORD;
        we_d    = 4'b1111;
        wdata_d = mem_write_data;
        if (sel_byte) begin
            size_d  = SZ_BYTE;
            we_d    = 4'b0001 << address_in[1:0];
            wdata_d = mem_write_data << {address_in[1:0], 3'b000};
        end else if (sel_half) begin
            size_d  = SZ_HALF;
            we_d    = 4'b0011 << {address_in[1], 1'b0};
            wdata_d = mem_write_data << {address_in[1], 4'b0000};
        end
        // Loads never drive strobes or data
        if (!mem_write_flag_in) begin
            we_d    = 4'b0000;
            wdata_d = 32'h0;
        end
    end

    // Load extraction from the latched address
    logic [31:0] byte_sh, half_sh, load_d;

    assign byte_sh = ram_read_data >> {addr_q[1:0], 3'b000};
    assign half_sh = ram_read_data >> {addr_q[1], 4'b0000};

    always_comb begin
        load_d = ram_read_data;
        case (size_q)
            SZ_BYTE: load_d = {{24{sign_q & byte_sh[7]}}, byte_sh[7:0]};
            SZ_HALF: load_d = {{16{sign_q & half_sh[15]}}, half_sh[15:0]};
            default: load_d = ram_read_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            size_q      <= SZ_BYTE;
            store_q     <= 1'b0;
            sign_q      <= 1'b0;
            addr_q      <= '0;
            we_q        <= 4'b0000;
            wdata_q     <= 32'h0;
            cnt_q       <= '0;
            load_q      <= 32'h0;
            err_load_q  <= 1'b0;
            err_store_q <= 1'b0;
            bad_vaddr_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            err_load_q  <= 1'b0;
            err_store_q <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (request) begin
                        if (aligned) begin
                            size_q  <= size_d;
                            store_q <= mem_write_flag_in;
                            sign_q  <= mem_sign_ext_flag_in;
                            addr_q  <= address_in;
                            we_q    <= we_d;
                            wdata_q <= wdata_d;
                            cnt_q   <= '0;
                            state_q <= S_ACCESS;
                        end else begin
                            err_store_q <= mem_write_flag_in;
                            err_load_q  <= !mem_write_flag_in;
                            bad_vaddr_q <= address_in;
                        end
                    end
                end
                S_ACCESS: begin
                    if (ram_ready) begin
                        if (!store_q) load_q <= load_d;
                        state_q <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        load_q    <= 32'h0;
                        timeout_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_access        = (state_q == S_ACCESS);
    assign ram_en           = in_access;
    assign ram_write_en     = in_access ? we_q : 4'b0000;
    assign ram_write_data   = in_access ? wdata_q : 32'h0;
    assign ram_addr         = in_access ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign stall_req        = in_access || (request && aligned);
    assign done             = (state_q == S_DONE);
    assign load_data_out    = load_q;
    assign addr_error_load  = err_load_q;
    assign addr_error_store = err_store_q;
    assign bad_vaddr        = bad_vaddr_q;
    assign timeout_error    = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr, sx, flush;
    logic [3:0]  sel;
    logic [31:0] wdata, addr;
    logic        ram_en, ram_ready;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr, ram_write_data, ram_read_data;
    logic        stall_req, done, ael, aes, tmo;
    logic [31:0] load_data_out, bad_vaddr;

    int checks   = 0;
    int failures = 0;

    // results of the last run_access
    int          r_en, r_stall, r_done_cyc, r_el, r_es, r_to, r_addr_chg;
    logic [31:0] r_addr, r_wd, r_ld;
    logic [3:0]  r_we;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .mem_read_flag_in(rd), .mem_write_flag_in(wr), .mem_sign_ext_flag_in(sx),
        .mem_sel_in(sel), .mem_write_data(wdata), .address_in(addr), .flush(flush),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_ready(ram_ready), .ram_read_data(ram_read_data),
        .stall_req(stall_req), .done(done), .load_data_out(load_data_out),
        .addr_error_load(ael), .addr_error_store(aes), .bad_vaddr(bad_vaddr),
        .timeout_error(tmo)
    );

    // Presents one instruction (entered at posedge+1) and observes it at each negedge.
    // The request is held until done, or for 'hold' cycles; ram_ready rises on the
    // (delay+1)-th ram_en cycle, never when delay < 0.
    task automatic run_access(input logic r, input logic w, input logic s, input logic [3:0] sl,
                              input logic [31:0] d, input logic [31:0] a, input int delay,
                              input logic [31:0] rdat, input int hold, input int max_cyc,
                              input logic fl);
        int cyc = 0;
        bit fin = 0;
        r_en = 0; r_stall = 0; r_done_cyc = 0; r_el = 0; r_es = 0; r_to = 0; r_addr_chg = 0;
        r_addr = 0; r_wd = 0; r_we = 0; r_ld = 0;
        rd = r; wr = w; sx = s; sel = sl; wdata = d; addr = a; flush = fl;
        while (!fin && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (cyc > hold) begin rd = 0; wr = 0; flush = 0; end
            if (stall_req) r_stall++;
            if (ael) r_el++;
            if (aes) r_es++;
            if (tmo) r_to++;
            if (ram_en) begin
                if (r_en == 0) begin
                    r_addr = ram_addr; r_we = ram_write_en; r_wd = ram_write_data;
                end else if (ram_addr !== r_addr) begin
                    r_addr_chg = 1;
                end
                ram_ready = (r_en == delay);
                ram_read_data = rdat;
                r_en++;
            end else begin
                ram_ready = 0;
            end
            if (done) begin
                r_done_cyc = cyc; r_ld = load_data_out;
                rd = 0; wr = 0; flush = 0; fin = 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 0; rd = 0; wr = 0; sx = 0; sel = 0; wdata = 0; addr = 0; flush = 0;
        ram_ready = 0; ram_read_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ram_en, ram_write_en, stall_req, done, ael, aes, tmo} !== 10'b0)
            begin failures++; $display("FAIL reset_ctrl: got %b want 0", {ram_en, ram_write_en, stall_req, done, ael, aes, tmo}); end
        checks++;
        if ({ram_addr, ram_write_data, load_data_out, bad_vaddr} !== 128'b0)
            begin failures++; $display("FAIL reset_data: got %h want 0", {ram_addr, ram_write_data, load_data_out, bad_vaddr}); end
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic test_store_byte();
        run_access(0, 1, 0, 4'b0001, 32'h0000_00AB, 32'h0000_1003, 0, 32'h0, 100, 40, 0);
        checks++; if (r_addr !== 32'h1000) begin failures++; $display("FAIL sb_addr: got %h want 00001000", r_addr); end
        checks++; if (r_we !== 4'b1000) begin failures++; $display("FAIL sb_we: got %b want 1000", r_we); end
        checks++; if (r_wd !== 32'hAB00_0000) begin failures++; $display("FAIL sb_wdata: got %h want ab000000", r_wd); end
        checks++; if (r_stall != 2) begin failures++; $display("FAIL sb_stall: got %0d want 2", r_stall); end
        checks++; if (r_done_cyc != 3) begin failures++; $display("FAIL sb_done_cycle: got %0d want 3", r_done_cyc); end
        checks++; if (r_en != 1) begin failures++; $display("FAIL sb_en_cycles: got %0d want 1", r_en); end
    endtask

    task automatic test_loads();
        run_access(1, 0, 1, 4'b0011, 32'h0, 32'h0000_2002, 0, 32'h8001_1234, 100, 40, 0);
        checks++; if (r_ld !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_signed: got %h want ffff8001", r_ld); end
        checks++; if ({r_we, r_wd} !== 36'h0) begin failures++; $display("FAIL lh_no_write: got %h want 0", {r_we, r_wd}); end
        run_access(1, 0, 0, 4'b0011, 32'h0, 32'h0000_2002, 0, 32'h8001_1234, 100, 40, 0);
        checks++; if (r_ld !== 32'h0000_8001) begin failures++; $display("FAIL lhu: got %h want 00008001", r_ld); end
        run_access(1, 0, 1, 4'b0001, 32'h0, 32'h0000_2001, 0, 32'h8001_1234, 100, 40, 0);
        checks++; if (r_ld !== 32'h0000_0012) begin failures++; $display("FAIL lb_signed: got %h want 00000012", r_ld); end
        run_access(1, 0, 1, 4'b0001, 32'h0, 32'h0000_2003, 0, 32'h8001_1234, 100, 40, 0);
        checks++; if (r_ld !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_signed_lane3: got %h want ffffff80", r_ld); end
    endtask

    task automatic test_misaligned();
        run_access(1, 0, 0, 4'b1111, 32'h0, 32'h0000_3001, 0, 32'h0, 1, 4, 0);
        checks++; if (r_el != 1 || r_es != 0) begin failures++; $display("FAIL lw_misaligned: got el=%0d es=%0d want 1 0", r_el, r_es); end
        checks++; if (r_en != 0 || r_stall != 0) begin failures++; $display("FAIL lw_mis_noaccess: got en=%0d stall=%0d want 0 0", r_en, r_stall); end
        checks++; if (bad_vaddr !== 32'h3001) begin failures++; $display("FAIL lw_bad_vaddr: got %h want 00003001", bad_vaddr); end
        run_access(0, 1, 0, 4'b0011, 32'h0, 32'h0000_3003, 0, 32'h0, 1, 4, 0);
        checks++; if (r_es != 1 || r_el != 0) begin failures++; $display("FAIL sh_misaligned: got es=%0d el=%0d want 1 0", r_es, r_el); end
        checks++; if (bad_vaddr !== 32'h3003) begin failures++; $display("FAIL sh_bad_vaddr: got %h want 00003003", bad_vaddr); end
    endtask

    task automatic test_wait_states();
        run_access(1, 0, 0, 4'b1111, 32'h0, 32'h0000_4000, 3, 32'hCAFE_F00D, 100, 40, 0);
        checks++; if (r_en != 4 || r_addr_chg != 0 || r_addr !== 32'h4000) begin failures++; $display("FAIL lw_wait_en: got en=%0d chg=%0d addr=%h want 4 0 00004000", r_en, r_addr_chg, r_addr); end
        checks++; if (r_stall != 5) begin failures++; $display("FAIL lw_wait_stall: got %0d want 5", r_stall); end
        checks++; if (r_ld !== 32'hCAFE_F00D) begin failures++; $display("FAIL lw_wait_data: got %h want cafef00d", r_ld); end
        run_access(0, 1, 0, 4'b1111, 32'h1122_3344, 32'h0000_4004, 1, 32'h5555_5555, 100, 40, 0);
        checks++; if (r_we !== 4'b1111 || r_wd !== 32'h1122_3344) begin failures++; $display("FAIL sw_lanes: got %b %h want 1111 11223344", r_we, r_wd); end
        checks++; if (r_ld !== 32'hCAFE_F00D) begin failures++; $display("FAIL sw_keeps_load: got %h want cafef00d", r_ld); end
    endtask

    task automatic test_timeout_flush();
        run_access(1, 0, 0, 4'b1111, 32'h0, 32'h0000_6000, -1, 32'h1234_5678, 100, 40, 0);
        checks++; if (r_en != 8) begin failures++; $display("FAIL timeout_en: got %0d want 8", r_en); end
        checks++; if (r_to != 1 || r_done_cyc != 10) begin failures++; $display("FAIL timeout_pulse: got to=%0d done_cyc=%0d want 1 10", r_to, r_done_cyc); end
        checks++; if (r_ld !== 32'h0) begin failures++; $display("FAIL timeout_data: got %h want 0", r_ld); end
        run_access(1, 0, 0, 4'b1111, 32'h0, 32'h0000_6100, 0, 32'h0, 1, 4, 1);
        checks++; if (r_en != 0 || r_stall != 0 || r_el != 0) begin failures++; $display("FAIL flush_blocks: got en=%0d stall=%0d el=%0d want 0 0 0", r_en, r_stall, r_el); end
    endtask

    task automatic test_reset_mid_access();
        int seen = 0;
        int guard = 0;
        rd = 1; wr = 0; sx = 0; sel = 4'b1111; addr = 32'h0000_7000; flush = 0; ram_ready = 0;
        while (seen < 2 && guard < 10) begin
            @(negedge clk);
            guard++;
            if (ram_en) seen++;
        end
        checks++; if (seen != 2) begin failures++; $display("FAIL rst_mid_setup: got %0d ram_en cycles want 2", seen); end
        rst = 0;
        @(negedge clk);
        checks++;
        if ({ram_en, stall_req, done, ael, aes, tmo, ram_write_en} !== 10'b0 || load_data_out !== 32'h0 || bad_vaddr !== 32'h0 || ram_addr !== 32'h0)
            begin failures++; $display("FAIL rst_mid_outputs: got en=%b stall=%b ld=%h bv=%h want all 0", ram_en, stall_req, load_data_out, bad_vaddr); end
        rd = 0;
        @(posedge clk); #1;
        rst = 1;
        run_access(0, 1, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_5000, 0, 32'h0, 100, 40, 0);
        checks++; if (r_en != 1 || r_done_cyc != 3 || r_addr !== 32'h5000) begin failures++; $display("FAIL sw_after_rst: got en=%0d done_cyc=%0d addr=%h want 1 3 00005000", r_en, r_done_cyc, r_addr); end
        checks++; if (r_we !== 4'b1111 || r_wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_after_rst_data: got %b %h want 1111 deadbeef", r_we, r_wd); end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_loads();
        test_misaligned();
        test_wait_states();
        test_timeout_flush();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
